lcd_spi_sequencer: RTL

Byte-stream sequencer between the CPU-side display write port and the 8-bit SPI transmitter. Buffers command/data bytes in a small FIFO, drives the display D/C line per byte, and feeds the transmitter one byte at a time over its LOAD/BUSY handshake. Optionally runs the display's power-on hardware reset (RESX) sequence before releasing the stream.

---
 rtl/lcd_spi_sequencer_pkg.sv | 20 ++
 rtl/lcd_spi_sequencer_if.sv | 10 +
 rtl/lcd_spi_sequencer_sync_fifo.sv | 51 +++++
 rtl/lcd_spi_sequencer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/lcd_spi_sequencer_pkg.sv
// Shared definitions for the LCD SPI byte sequencer: FIFO entry layout,
// D/C line values and sequencer state encoding.
package lcd_pkg;

  localparam int unsigned ENTRY_W = 9;
  localparam int unsigned DC_BIT  = 8;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  typedef enum logic [2:0] {
    ST_RST_LOW,
    ST_RST_WAIT,
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_START,
    ST_WAIT_DONE
  } seq_state_e;

endpackage

// File: rtl/lcd_spi_sequencer_if.sv
// LOAD/BUSY handshake and D/C line between the sequencer and the 8-bit SPI transmitter.
interface lcd_spi_sequencer_if;
  logic       SPI_LOAD;
  logic [7:0] SPI_IN;
  logic       SPI_BUSY;
  logic       DCX;

  modport master (output SPI_LOAD, output SPI_IN, output DCX, input SPI_BUSY);
  modport slave  (input SPI_LOAD, input SPI_IN, input DCX, output SPI_BUSY);
endinterface

// File: rtl/lcd_spi_sequencer_sync_fifo.sv
// Single-clock FIFO; a write when full is ignored unless a pop frees the slot on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             wr_ok, rd_ok;

  assign rd_ok = rd_en_i && !empty_o;
  assign wr_ok = wr_en_i && (!full_o || rd_ok);

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + 1'b1;
      if (rd_ok) rptr_q <= rptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data_o = mem_q[rptr_q];
  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
endmodule

// File: rtl/lcd_spi_sequencer.sv
// LCD SPI byte sequencer: FIFO-buffered command/data stream onto the transmitter LOAD/BUSY handshake.
// Define LCD_RESX_SEQ_EN to run the RESX power-on reset sequence before the stream is released.
module lcd_spi_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH            = 16,
  parameter int unsigned RESX_LOW_CYCLES  = 1000,
  parameter int unsigned RESX_WAIT_CYCLES = 12000000
) (
  input  logic                      CLK_100MHz,
  input  logic                      RESET_N,
  input  logic                      WR_EN,
  input  logic [ENTRY_W-1:0]        WR_DATA,
  output logic                      FULL,
  output logic                      EMPTY,
  output logic                      OVERFLOW,
  output logic                      READY,
  output logic                      ACTIVE,
  output logic                      RESX,
  lcd_spi_sequencer_if.master       spi
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RESX_LOW_CYCLES == 0 || RESX_WAIT_CYCLES == 0)
  begin : g_cfg_check
    $error("lcd_spi_sequencer: DEPTH must be a power of two >= 2 and RESX cycle counts non-zero");
  end

  seq_state_e          state_q;
  logic                load_q, dcx_q, ovf_q;
  logic [7:0]          byte_q;
  logic [ENTRY_W-1:0]  head;
  logic                fifo_full, fifo_empty, pop, ready;
  logic [$clog2(DEPTH):0] fifo_count;

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i     (CLK_100MHz),
    .rst_ni    (RESET_N),
    .wr_en_i   (WR_EN),
    .wr_data_i (WR_DATA),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Waiting for BUSY low in IDLE also covers a transmitter still finishing a byte across reset.
  assign pop = (state_q == ST_IDLE) && !fifo_empty && !spi.SPI_BUSY;

`ifdef LCD_RESX_SEQ_EN
  logic        resx_q, ready_q;
  logic [31:0] cnt_q;
  assign ready = ready_q;
  assign RESX  = resx_q;
`else
  assign ready = 1'b1;
  assign RESX  = 1'b1;
`endif

  always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
`ifdef LCD_RESX_SEQ_EN
      state_q <= ST_RST_LOW;
      resx_q  <= 1'b0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
`else
      state_q <= ST_IDLE;
`endif
      load_q  <= 1'b0;
      byte_q  <= '0;
      dcx_q   <= DC_DATA;
      ovf_q   <= 1'b0;
    end else begin
      load_q <= 1'b0;
      if (WR_EN && fifo_full && !pop) ovf_q <= 1'b1;
      case (state_q)
`ifdef LCD_RESX_SEQ_EN
        ST_RST_LOW: begin
          if (cnt_q == 32'(RESX_LOW_CYCLES - 1)) begin
            cnt_q   <= '0;
            resx_q  <= 1'b1;
            state_q <= ST_RST_WAIT;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_RST_WAIT: begin
          if (cnt_q == 32'(RESX_WAIT_CYCLES - 1)) begin
            cnt_q   <= '0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
`endif
        ST_IDLE: begin
          if (pop) begin
            byte_q  <= head[7:0];
            dcx_q   <= head[DC_BIT];
            load_q  <= 1'b1;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD:       state_q <= ST_WAIT_START;
        ST_WAIT_START: if (spi.SPI_BUSY)  state_q <= ST_WAIT_DONE;
        ST_WAIT_DONE:  if (!spi.SPI_BUSY) state_q <= ST_IDLE;
        default:       state_q <= ST_IDLE;
      endcase
    end
  end

  assign spi.SPI_LOAD = load_q;
  assign spi.SPI_IN   = byte_q;
  assign spi.DCX      = dcx_q;
  assign FULL         = fifo_full;
  assign EMPTY        = fifo_empty;
  assign OVERFLOW     = ovf_q;
  assign READY        = ready;
  assign ACTIVE       = (fifo_count != '0) || ((state_q != ST_IDLE) && ready);
endmodule
